// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier family.
package mult_pkg;

    // Widest operand the magnitude helper supports.
    localparam int unsigned ABS_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // Magnitude of a sign-extended two's-complement value; |-2^(n-1)| fits in n bits.
    function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x);
        return x[ABS_W-1] ? ABS_W'(-x) : x;
    endfunction

endpackage

// File: rtl/mult_pp_step.sv
// One radix-2^K step: upper accumulator plus mag_a times K multiplier bits.
module mult_pp_step #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 2
) (
    input  logic [N-1:0]   mag_a,
    input  logic [K-1:0]   mbits,
    input  logic [N-1:0]   upper,
    output logic [N+K-1:0] sum
);

    localparam int unsigned SW = N + K;

    // (2^N-1) + (2^N-1)(2^K-1) < 2^(N+K), so the sum never overflows SW bits.
    always_comb begin
        sum = SW'(upper) + SW'(mag_a) * SW'(mbits);
    end

endmodule

// File: rtl/mult_serial_radix.sv
// Sequential N x N multiplier retiring K multiplier bits per cycle, signed or unsigned.
module mult_serial_radix
    import mult_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned K = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           is_signed,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] produto
);

    localparam int unsigned STEPS = N / K;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned W2    = 2 * N;

    if (N < 4 || K < 1 || K > N || (N % K) != 0 || N > ABS_W) begin : g_bad_params
        $error("mult_serial_radix: illegal N/K combination");
    end

    mult_state_t        state;
    mult_state_t        state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [W2-1:0]      acc;
    logic [N-1:0]       mag_a;
    logic               neg;
    logic [N+K-1:0]     pp_sum;
    logic [W2-1:0]      acc_step_c;
    logic [N-1:0]       mag_a_c;
    logic [N-1:0]       mag_b_c;

    // Operand magnitudes; raw operands pass through in unsigned mode.
    always_comb begin
        mag_a_c = A;
        mag_b_c = B;
        if (is_signed) begin
            mag_a_c = N'(abs_n({{(ABS_W-N){A[N-1]}}, A}));
            mag_b_c = N'(abs_n({{(ABS_W-N){B[N-1]}}, B}));
        end
    end

    mult_pp_step #(.N(N), .K(K)) u_pp_step (
        .mag_a (mag_a),
        .mbits (acc[K-1:0]),
        .upper (acc[W2-1:N]),
        .sum   (pp_sum)
    );

    // The new partial sum lands on top while the consumed multiplier bits shift out.
    if (K < N) begin : g_shift
        assign acc_step_c = {pp_sum, acc[N-1:K]};
    end else begin : g_full
        assign acc_step_c = pp_sum;
    end

    assign in_ready = (state == IDLE) && reset_n;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE is left only on an actual handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)               state_nxt = CALC;
            CALC:    if (cnt == '0)              state_nxt = FIX;
            FIX:                                 state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Datapath, counter, result and valid registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            mag_a     <= '0;
            neg       <= 1'b0;
            produto   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == DONE) && !(out_valid && out_ready);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_a <= mag_a_c;
                        acc   <= {N'(0), mag_b_c};
                        neg   <= is_signed & (A[N-1] ^ B[N-1]);
                        cnt   <= CNT_W'(STEPS - 1);
                    end
                end
                CALC: begin
                    acc <= acc_step_c;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    produto <= neg ? W2'(-acc) : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_serial_radix.sv
// Self-checking bench: six multiplier configurations, scoreboard on every product transfer.
module tb_mult_serial_radix;

    localparam int NI = 6;

    function automatic int n_of(input int g);
        return (g < 3) ? 8 : 32;
    endfunction

    function automatic int k_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 8;
            3:       return 1;
            4:       return 2;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv   [NI];
    logic        sg   [NI];
    logic [31:0] av   [NI];
    logic [31:0] bv   [NI];
    logic        ordy [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic [63:0] pr   [NI];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          cur     = 0;
    int          rx_cnt  = 0;
    logic [63:0] sb_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NN = n_of(g);
        localparam int KK = k_of(g);
        logic [2*NN-1:0] p;
        logic            r;
        logic            v;
        mult_serial_radix #(.N(NN), .K(KK)) dut (
            .clock     (clk),
            .reset_n   (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (r),
            .is_signed (sg[g]),
            .A         (av[g][NN-1:0]),
            .B         (bv[g][NN-1:0]),
            .out_valid (v),
            .out_ready (ordy[g]),
            .produto   (p)
        );
        assign ir[g] = r;
        assign ov[g] = v;
        assign pr[g] = 64'(p);
    end

    // Reference product, computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input int n, input logic s,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        m;
        logic [63:0]        r;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        m = (n == 32) ? 64'hFFFF_FFFF : ((64'd1 << n) - 64'd1);
        if (s) begin
            sa = $signed(64'(a) << (64 - n)) >>> (64 - n);
            sb = $signed(64'(b) << (64 - n)) >>> (64 - n);
            r  = 64'(sa * sb);
        end else begin
            r = (64'(a) & m) * (64'(b) & m);
        end
        if (n < 32) r = r & ((64'd1 << (2 * n)) - 64'd1);
        return r;
    endfunction

    // Pops an expected value on every cycle a transfer will happen on instance cur.
    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ov[cur] === 1'b1 && ordy[cur] === 1'b1) begin
                rx_cnt++;
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra inst=%0d got=%h expected no output", cur, pr[cur]);
                end else begin
                    e = sb_q.pop_front();
                    if (pr[cur] !== e) begin
                        n_fail++;
                        $display("FAIL sb_product inst=%0d got=%h expected=%h", cur, pr[cur], e);
                    end
                end
            end
        end
    endtask

    // Present operands, wait for acceptance, record expectation; returns at accept edge + #1.
    task automatic send(input int g, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int acc_cyc);
        int w;
        iv[g] = 1'b1; sg[g] = s; av[g] = a; bv[g] = b;
        w = 0;
        @(negedge clk);
        while (ir[g] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (ir[g] !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout inst=%0d in_ready=%b expected 1", g, ir[g]);
            iv[g] = 1'b0;
            acc_cyc = -1;
            return;
        end
        sb_q.push_back(ref_mul(n_of(g), s, a, b));
        @(posedge clk); #1;
        acc_cyc = cyc;
        iv[g] = 1'b0;
        av[g] = $urandom(); bv[g] = $urandom(); sg[g] = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for out_valid; returns at a negedge with the cycle count.
    task automatic wait_valid(input int g, output int c);
        int w;
        w = 0;
        @(negedge clk);
        while (ov[g] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        c = cyc;
        if (ov[g] !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL valid_timeout inst=%0d out_valid=%b expected 1", g, ov[g]);
        end
    endtask

    task automatic run_one(input int g, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_p, input int exp_lat, input string name);
        int ac;
        int c;
        cur = g;
        send(g, s, a, b, ac);
        wait_valid(g, c);
        n_tests++;
        if (c - ac !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency got=%0d expected=%0d", name, c - ac, exp_lat);
        end
        n_tests++;
        if (pr[g] !== exp_p) begin
            n_fail++;
            $display("FAIL %s_value got=%h expected=%h", name, pr[g], exp_p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            iv[g] = 1'b0; sg[g] = 1'b0; av[g] = '0; bv[g] = '0; ordy[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_tests++;
            if (ir[g] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready inst=%0d got=%b expected 0", g, ir[g]); end
            n_tests++;
            if (ov[g] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid inst=%0d got=%b expected 0", g, ov[g]); end
            n_tests++;
            if (pr[g] !== 64'd0) begin n_fail++; $display("FAIL reset_produto inst=%0d got=%h expected 0", g, pr[g]); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_tests++;
            if (ir[g] !== 1'b1) begin n_fail++; $display("FAIL release_in_ready inst=%0d got=%b expected 1", g, ir[g]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        run_one(0, 1'b0, 32'd255, 32'd255, 64'hFE01, 6, "u255x255");
    endtask

    task automatic test_signed();
        run_one(0, 1'b1, 32'h80, 32'h80, 64'h4000, 6, "s_m128xm128");
        run_one(0, 1'b1, 32'hFD, 32'h05, 64'hFFF1, 6, "s_m3x5");
        run_one(0, 1'b1, 32'h7F, 32'h80, 64'hC080, 6, "s_127xm128");
    endtask

    task automatic test_radix_extremes();
        run_one(1, 1'b0, 32'd0, 32'd200, 64'd0,   10, "k1_0x200");
        run_one(1, 1'b0, 32'd1, 32'd200, 64'd200, 10, "k1_1x200");
        run_one(2, 1'b0, 32'd0, 32'd200, 64'd0,   3,  "k8_0x200");
        run_one(2, 1'b0, 32'd1, 32'd200, 64'd200, 3,  "k8_1x200");
    endtask

    task automatic test_backpressure();
        int ac;
        int c;
        cur = 0;
        ordy[0] = 1'b0;
        send(0, 1'b0, 32'd13, 32'd11, ac);
        wait_valid(0, c);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            iv[0] = 1'b1; av[0] = $urandom(); bv[0] = $urandom(); sg[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if (pr[0] !== 64'd143) begin n_fail++; $display("FAIL bp_hold_produto cyc=%0d got=%h expected=%h", i, pr[0], 64'd143); end
            n_tests++;
            if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b expected 0", i, ir[0]); end
            n_tests++;
            if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b expected 1", i, ov[0]); end
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_xfer got=%b expected 1", ir[0]); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup cyc=%0d got=%b expected 0", i, ov[0]); end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ac;
        cur = 0;
        send(0, 1'b0, 32'd100, 32'd3, ac);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        n_tests++;
        if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b expected 0", ov[0]); end
        n_tests++;
        if (pr[0] !== 64'd0) begin n_fail++; $display("FAIL midreset_produto got=%h expected 0", pr[0]); end
        n_tests++;
        if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b expected 1", ir[0]); end
        @(posedge clk); #1;
        run_one(0, 1'b0, 32'd7, 32'd9, 64'd63, 6, "after_reset_7x9");
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    task automatic test_back_to_back();
        int ac;
        int w;
        int start_rx;
        bit drv_done;
        for (int g = 3; g < NI; g++) begin
            cur = g;
            start_rx = rx_cnt;
            drv_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        send(g, 1'($urandom_range(0, 1)), pick_operand(), pick_operand(), ac);
                    end
                    drv_done = 1'b1;
                end
                begin
                    while (!drv_done) begin
                        @(posedge clk); #1;
                        ordy[g] = 1'($urandom_range(0, 1));
                    end
                end
            join
            ordy[g] = 1'b1;
            w = 0;
            while (sb_q.size() != 0 && w < 300) begin
                @(posedge clk);
                w++;
            end
            @(posedge clk); #1;
            n_tests++;
            if (rx_cnt - start_rx !== 40) begin
                n_fail++;
                $display("FAIL b2b_count inst=%0d got=%0d expected=40", g, rx_cnt - start_rx);
            end
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_unsigned();
        test_signed();
        test_radix_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
